dpram_bytewr: RTL and testbench
===============================

# dpram_bytewr

Parametrised simple-dual-port data RAM with one synchronous write port, byte-lane strobes and a valid/ready read port with a registered, stallable response. It replaces the 8-bit asynchronous-read RAM behind the core's data-memory path. It gives the LSU word-wide accesses, sub-word stores, write-first collision forwarding and back-pressure on read responses.

## Interface
- DATA_W, default 32: data width in bits; must be a multiple of 8.
- DEPTH, default 8192: number of DATA_W words; need not be a power of two.
- ADDR_W, default $clog2(DEPTH): word address width, derived from DEPTH.
- NB, default DATA_W/8: byte lanes, derived from DATA_W.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- we_i  in  1  write enable.
- waddr_i  in  ADDR_W  write word address.
- wdata_i  in  DATA_W  write data.
- wstrb_i  in  NB  byte-lane strobes; bit k writes wdata_i[8k+7:8k].
- rreq_valid_i  in  1  read request valid.
- rreq_ready_o  out  1  read request ready.
- raddr_i  in  ADDR_W  read word address.
- rrsp_valid_o  out  1  read response valid.
- rrsp_ready_i  in  1  response consumer ready.
- rdata_o  out  DATA_W  read data; forced to 0 while rrsp_valid_o = 0.

## Operation
- Write: when we_i=1 and waddr_i < DEPTH, each lane k with wstrb_i[k]=1 updates at the clock edge.
  - we_i=1 with wstrb_i=0 is a legal no-op.
  - An address ≥ DEPTH is silently dropped.
- Read accept: a read is accepted when rreq_valid_i & rreq_ready_o. The array is read in the accept cycle and the result is captured into the response register at the same edge.
- Ready rule: rreq_ready_o = !rrsp_valid_o | rrsp_ready_i. The path is a single-stage pipeline; it gives one read per cycle when the consumer never stalls.
- Response state (1 bit, rsp_full):
  - EMPTY→FULL on accept.
  - FULL→FULL on simultaneous accept and consume; the new data replaces the old.
  - FULL→EMPTY on consume with no accept.
  - FULL holds while rrsp_ready_i=0.
- Collision, write-first: if an accepted read and a write target the same in-range address in the same cycle, strobed lanes return wdata_i and unstrobed lanes return the old array bytes.
- Snapshot: a held response is not altered by later writes to its address.
- Out-of-range read (raddr_i ≥ DEPTH): accepted normally; response data = 0.
- Array contents are not reset and are undefined after power-up.
- rdata_o = response register masked by rrsp_valid_o.

## Timing
- Reset values: rrsp_valid_o=0, rdata_o=0, response register=0. rreq_ready_o=1 while in reset and after.
- Read latency: data is valid on rrsp_valid_o exactly 1 cycle after the accept edge.
- Write-to-read visibility: a read accepted in the same cycle as a write sees the new data (forwarded); a read accepted later reads it from the array.
- Back-pressure: rrsp_valid_o and rdata_o stay stable while rrsp_valid_o=1 and rrsp_ready_i=0.
- rreq_ready_o is combinational from rrsp_ready_i. There is no path from rreq_valid_i to rreq_ready_o.
- Reset asserted mid-operation:
  - a pending response is discarded immediately (asynchronous);
  - a write on the edge coincident with deassertion is not guaranteed;
  - the array keeps its contents.
- Write port has no handshake and is always accepted.

## Structure
- Package ram_pkg: default DATA_W/DEPTH constants and a byte-lane count function. It is shared with the LSU and the instruction RAM.
- Sub-module ram_lane: one 8-bit × DEPTH synchronous-write, combinational-read array with its own lane write enable. It is instantiated NB times in a generate loop.
- Top level holds the range check, forwarding mux, response register and handshake.

## Test plan
- Reset: hold rst_n=0 and drive traffic → rrsp_valid_o=0, rdata_o=0, rreq_ready_o=1. Release, write 0xDEADBEEF at addr 5 with strb 0xF, read addr 5 → 0xDEADBEEF one cycle after accept.
- Byte strobes: addr 7 holds 0x11223344; write 0xAABBCCDD strb 0b0101 → read returns 0x11BB33DD.
- Collision: addr 9 holds 0; in the same cycle write 0x12345678 strb 0b1100 and accept a read of addr 9 → response 0x12340000.
- Stall: accept a read of addr 3 (0xCAFEF00D) with rrsp_ready_i=0 for 4 cycles while writing 0 to addr 3 → output stays 0xCAFEF00D, rreq_ready_o=0. Release → consumed, rreq_ready_o=1.
- Streaming: back-to-back reads of addr 0..15 with rrsp_ready_i=1 → 16 responses on 16 consecutive cycles, in order.
- Range and reset: DEPTH=6000, read addr 6000 → 0 and write to 6000 ignored. Assert rst_n while a response is held → rrsp_valid_o drops at once and array data survives.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared RAM defaults and helpers used by the data RAM, the LSU and the instruction RAM.
package ram_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8192;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic int unsigned byte_lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte lane of the data RAM: synchronous write, combinational read, no reset on contents.
module ram_lane #(
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dpram_bytewr.sv
// Simple-dual-port data RAM: byte-strobed write port, valid/ready read port with a stallable response register.
module dpram_bytewr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NB     = byte_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [NB-1:0]     wstrb_i,
  input  logic              rreq_valid_i,
  output logic              rreq_ready_o,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic              rrsp_valid_o,
  input  logic              rrsp_ready_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic              wr_hit;
  logic              rd_ok;
  logic              accept;
  logic [DATA_W-1:0] arr_data;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] rsp_data;
  rsp_state_e        state;

  assign wr_hit = we_i & ({1'b0, waddr_i} < LIMIT);
  assign rd_ok  = {1'b0, raddr_i} < LIMIT;

  for (genvar k = 0; k < NB; k++) begin : g_lane
    ram_lane #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk   (clk),
      .we    (wr_hit & wstrb_i[k]),
      .waddr (waddr_i),
      .wdata (wdata_i[8*k +: 8]),
      .raddr (raddr_i),
      .rdata (arr_data[8*k +: 8])
    );
  end

  // Write-first: strobed lanes of a same-cycle write to the read address bypass the array.
  always_comb begin
    fwd_data = arr_data;
    if (wr_hit && (waddr_i == raddr_i)) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wstrb_i[k]) fwd_data[8*k +: 8] = wdata_i[8*k +: 8];
      end
    end
    if (!rd_ok) fwd_data = '0;
  end

  assign rrsp_valid_o = (state == RSP_FULL);
  assign rreq_ready_o = !rrsp_valid_o | rrsp_ready_i;
  assign accept       = rreq_valid_i & rreq_ready_o;
  assign rdata_o      = rrsp_valid_o ? rsp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RSP_EMPTY;
      rsp_data <= '0;
    end else if (accept) begin
      state    <= RSP_FULL;
      rsp_data <= fwd_data;
    end else if (rrsp_ready_i) begin
      state    <= RSP_EMPTY;
    end
  end

endmodule

// File: tb/tb_dpram_bytewr.sv
// Directed bench for dpram_bytewr with a response scoreboard and a cycle-level handshake model.
module tb_dpram_bytewr;

  localparam int DW  = 32;
  localparam int DEP = 6000;
  localparam int AW  = $clog2(DEP);
  localparam int NBL = DW / 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           we_i;
  logic [AW-1:0]  waddr_i;
  logic [DW-1:0]  wdata_i;
  logic [NBL-1:0] wstrb_i;
  logic           rreq_valid_i;
  logic           rreq_ready_o;
  logic [AW-1:0]  raddr_i;
  logic           rrsp_valid_o;
  logic           rrsp_ready_i;
  logic [DW-1:0]  rdata_o;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] sb [$];
  logic          mdl_valid = 1'b0;

  always #5 clk = ~clk;

  dpram_bytewr #(
    .DATA_W (DW),
    .DEPTH  (DEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .wstrb_i      (wstrb_i),
    .rreq_valid_i (rreq_valid_i),
    .rreq_ready_o (rreq_ready_o),
    .raddr_i      (raddr_i),
    .rrsp_valid_o (rrsp_valid_o),
    .rrsp_ready_i (rrsp_ready_i),
    .rdata_o      (rdata_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_read(input int a);
    logic [DW-1:0] d;
    if (a >= DEP) return '0;
    d = mdl[a];
    if (we_i && int'(waddr_i) == a) begin
      for (int k = 0; k < NBL; k++)
        if (wstrb_i[k]) d[8*k +: 8] = wdata_i[8*k +: 8];
    end
    return d;
  endfunction

  // One clock: check outputs at the negedge, advance the model, return 1 ns after the posedge.
  task automatic cycle();
    logic mdl_ready;
    logic acc;
    logic nxt_valid;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_valid", rrsp_valid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_ready", rreq_ready_o, 1);
      mdl_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    mdl_ready = !mdl_valid || rrsp_ready_i;
    chk("valid", rrsp_valid_o, mdl_valid);
    chk("ready", rreq_ready_o, mdl_ready);
    if (mdl_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("rdata", rdata_o, sb[0]);
        if (rrsp_ready_i) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end else begin
      chk("rdata_idle", rdata_o, 0);
    end
    acc = rreq_valid_i && mdl_ready;
    if (acc) sb.push_back(expect_read(int'(raddr_i)));
    nxt_valid = acc ? 1'b1 : (rrsp_ready_i ? 1'b0 : mdl_valid);
    if (we_i && int'(waddr_i) < DEP) begin
      for (int k = 0; k < NBL; k++)
        if (wstrb_i[k]) mdl[int'(waddr_i)][8*k +: 8] = wdata_i[8*k +: 8];
    end
    @(posedge clk); #1;
    mdl_valid = nxt_valid;
  endtask

  task automatic write1(input int a, input logic [DW-1:0] d, input logic [NBL-1:0] s);
    we_i = 1'b1; waddr_i = AW'(a); wdata_i = d; wstrb_i = s;
    cycle();
    we_i = 1'b0; wstrb_i = '0;
  endtask

  task automatic read1(input int a);
    rreq_valid_i = 1'b1; raddr_i = AW'(a);
    cycle();
    rreq_valid_i = 1'b0;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; wstrb_i = '0;
    rreq_valid_i = 1'b1; raddr_i = AW'(5); rrsp_ready_i = 1'b0;

    // Traffic during reset must not produce a response.
    repeat (3) cycle();
    rst_n = 1'b1;
    rreq_valid_i = 1'b0; rrsp_ready_i = 1'b1;
    cycle();

    for (int i = 0; i < 16; i++) write1(i, 32'h1000_0000 + 32'h0101_0101 * i, 4'hF);

    write1(5, 32'hDEADBEEF, 4'hF);
    read1(5);
    cycle();

    write1(7, 32'h11223344, 4'hF);
    write1(7, 32'hAABBCCDD, 4'b0101);
    read1(7);
    cycle();

    // Same-cycle write and read of addr 9: upper lanes forwarded.
    write1(9, 32'h0, 4'hF);
    we_i = 1'b1; waddr_i = AW'(9); wdata_i = 32'h12345678; wstrb_i = 4'b1100;
    read1(9);
    we_i = 1'b0; wstrb_i = '0;
    cycle();

    // Held response is a snapshot while addr 3 is overwritten.
    write1(3, 32'hCAFEF00D, 4'hF);
    rrsp_ready_i = 1'b0;
    read1(3);
    we_i = 1'b1; waddr_i = AW'(3); wdata_i = '0; wstrb_i = 4'hF;
    rreq_valid_i = 1'b1; raddr_i = AW'(4);
    repeat (4) begin
      cycle();
      chk("stall_ready", rreq_ready_o, 0);
      chk("stall_data", rdata_o, 32'hCAFEF00D);
    end
    we_i = 1'b0; wstrb_i = '0; rreq_valid_i = 1'b0;
    rrsp_ready_i = 1'b1;
    cycle();
    chk("release_ready", rreq_ready_o, 1);
    cycle();

    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      rreq_valid_i = 1'b1; raddr_i = AW'(i);
      cycle();
    end
    rreq_valid_i = 1'b0;
    cycle();
    chk("stream_count", 32'(pops - p0), 16);

    write1(DEP, 32'hFFFF_FFFF, 4'hF);
    read1(DEP);
    we_i = 1'b1; waddr_i = AW'(DEP); wdata_i = 32'h7777_7777; wstrb_i = 4'hF;
    read1(DEP);
    we_i = 1'b0; wstrb_i = '0;
    read1(8191);
    write1(DEP - 1, 32'h5A5A_A5A5, 4'hF);
    write1(0, 32'h0BAD_F00D, 4'h0);
    read1(DEP - 1);
    read1(0);
    cycle();

    // Asynchronous reset with a response held.
    rrsp_ready_i = 1'b0;
    read1(5);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", rrsp_valid_o, 0);
    chk("async_rdata", rdata_o, 0);
    chk("async_ready", rreq_ready_o, 1);
    sb.delete();
    mdl_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    rrsp_ready_i = 1'b1;
    cycle();
    read1(5);
    read1(7);
    cycle();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
